// File: rtl/conv_frame_ctrl_if.sv
// Stream bundle between the frame sequencer, the bit source, the encoder and the
// symbol sink. The controller uses the master modport.
interface conv_frame_ctrl_if #(
    parameter int SYM_W = 2
);
    logic             i_frame_start;
    logic             i_bit_valid;
    logic             i_bit;
    logic             o_bit_ready;
    logic             o_enc_en;
    logic             o_enc_bit;
    logic [SYM_W-1:0] i_enc_sym;
    logic [SYM_W-1:0] o_sym;
    logic             o_sym_valid;
    logic             i_sym_ready;
    logic             o_sof;
    logic             o_eof;
    logic             o_busy;
    logic             o_done;

    modport master (
        input  i_frame_start, i_bit_valid, i_bit, i_enc_sym, i_sym_ready,
        output o_bit_ready, o_enc_en, o_enc_bit, o_sym, o_sym_valid,
               o_sof, o_eof, o_busy, o_done
    );

    modport slave (
        output i_frame_start, i_bit_valid, i_bit, i_enc_sym, i_sym_ready,
        input  o_bit_ready, o_enc_en, o_enc_bit, o_sym, o_sym_valid,
               o_sof, o_eof, o_busy, o_done
    );
endinterface

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the K=3 rate-1/2 convolutional encoder: steps the encoder
// per accepted info bit, appends a zero tail, and registers symbols with SOF/EOF.
module conv_frame_ctrl #(
    parameter int FRAME_LEN = 8,
    parameter int TAIL_LEN  = 2,
    parameter int SYM_W     = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    conv_frame_ctrl_if.master  bus
);
    localparam int MAX_LEN = (FRAME_LEN > TAIL_LEN) ? FRAME_LEN : TAIL_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);
    localparam bit HAS_TAIL = (TAIL_LEN > 0);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(FRAME_LEN - 1);
    // Only meaningful when a tail exists; pinned to zero otherwise.
    localparam logic [CNT_W-1:0] TAIL_LAST = HAS_TAIL ? CNT_W'(TAIL_LEN - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL,
        FLUSH
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             out_free;
    logic             step;
    logic             sym_take;
    logic             sym_first;
    logic             sym_last;

    assign out_free = !bus.o_sym_valid || bus.i_sym_ready;
    assign sym_take = bus.o_sym_valid && bus.i_sym_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (bus.i_frame_start) begin
                    state_nxt = DATA;
                    cnt_nxt   = '0;
                end
            end
            DATA: begin
                if (step) begin
                    if (cnt == DATA_LAST) begin
                        state_nxt = HAS_TAIL ? TAIL : FLUSH;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            TAIL: begin
                if (step) begin
                    if (cnt == TAIL_LAST) begin
                        state_nxt = FLUSH;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            FLUSH: begin
                // The only symbol still pending here is the EOF symbol.
                if (sym_take) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        step            = 1'b0;
        bus.o_bit_ready = 1'b0;
        bus.o_enc_bit   = 1'b0;
        bus.o_busy      = (state != IDLE);
        bus.o_done      = (state == FLUSH) && sym_take;
        sym_first       = (state == DATA) && (cnt == '0);
        sym_last        = ((state == DATA) && (cnt == DATA_LAST) && !HAS_TAIL) ||
                          ((state == TAIL) && (cnt == TAIL_LAST));
        unique case (state)
            DATA: begin
                step            = bus.i_bit_valid && out_free;
                bus.o_bit_ready = out_free;
                bus.o_enc_bit   = bus.i_bit;
            end
            TAIL:    step = out_free;
            default: step = 1'b0;
        endcase
        bus.o_enc_en = step;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_sym       <= '0;
            bus.o_sym_valid <= 1'b0;
            bus.o_sof       <= 1'b0;
            bus.o_eof       <= 1'b0;
        end else if (step) begin
            bus.o_sym       <= bus.i_enc_sym;
            bus.o_sym_valid <= 1'b1;
            bus.o_sof       <= sym_first;
            bus.o_eof       <= sym_last;
        end else if (bus.i_sym_ready) begin
            bus.o_sym_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Scoreboard bench for conv_frame_ctrl: stimulus pushes hand-computed symbols,
// monitors pop and compare on every output handshake.
module tb_conv_frame_ctrl;
    typedef struct packed {
        logic [1:0] sym;
        logic       sof;
        logic       eof;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt = 0;
    int   done_cnt = 0;
    int   done1_cnt = 0;
    exp_t q[$];
    exp_t q1[$];
    logic [1:0] es, es1;
    logic       prev_stall;
    logic [3:0] prev_out;

    conv_frame_ctrl_if #(.SYM_W(2)) bus ();
    conv_frame_ctrl_if #(.SYM_W(2)) bus1 ();

    conv_frame_ctrl #(.FRAME_LEN(4), .TAIL_LEN(2), .SYM_W(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
    );
    conv_frame_ctrl #(.FRAME_LEN(1), .TAIL_LEN(0), .SYM_W(2)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Encoder G=[111][101]; es = {d1, d2}, symbol = {b^d2, b^d1^d2}.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) es <= 2'b00;
        else if (bus.o_enc_en) es <= {bus.o_enc_bit, es[1]};
    always @(posedge clk or negedge rst_n)
        if (!rst_n) es1 <= 2'b00;
        else if (bus1.o_enc_en) es1 <= {bus1.o_enc_bit, es1[1]};
    assign bus.i_enc_sym  = {bus.o_enc_bit ^ es[0], bus.o_enc_bit ^ es[1] ^ es[0]};
    assign bus1.i_enc_sym = {bus1.o_enc_bit ^ es1[0], bus1.o_enc_bit ^ es1[1] ^ es1[0]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic hs;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            e  = '0;
            hs = bus.o_sym_valid && bus.i_sym_ready;
            if (hs) begin
                hs_cnt++;
                if (q.size() == 0) chk("unexpected_sym", 32'(bus.o_sym), 32'hFFFF);
                else begin
                    e = q.pop_front();
                    chk("sym", 32'(bus.o_sym), 32'(e.sym));
                    chk("sof", 32'(bus.o_sof), 32'(e.sof));
                    chk("eof", 32'(bus.o_eof), 32'(e.eof));
                end
            end
            chk("done", 32'(bus.o_done), 32'(hs && e.eof));
            if (bus.o_done) done_cnt++;
            if (bus.o_sym_valid && !bus.i_sym_ready)
                chk("stall_no_step", 32'({bus.o_enc_en, bus.o_bit_ready}), 32'h0);
            if (prev_stall)
                chk("stall_hold", 32'({bus.o_sym_valid, bus.o_sym, bus.o_sof, bus.o_eof}),
                    32'({1'b1, prev_out}));
            if (!bus.o_busy)
                chk("idle_quiet", 32'({bus.o_enc_en, bus.o_bit_ready}), 32'h0);
            prev_stall = bus.o_sym_valid && !bus.i_sym_ready;
            prev_out   = {bus.o_sym, bus.o_sof, bus.o_eof};
        end
    end

    always @(negedge clk) begin
        exp_t e;
        logic hs;
        if (rst_n) begin
            e  = '0;
            hs = bus1.o_sym_valid && bus1.i_sym_ready;
            if (hs) begin
                if (q1.size() == 0) chk("dut1_unexpected_sym", 32'(bus1.o_sym), 32'hFFFF);
                else begin
                    e = q1.pop_front();
                    chk("dut1_sym", 32'({bus1.o_sym, bus1.o_sof, bus1.o_eof}), 32'(e));
                end
            end
            chk("dut1_done", 32'(bus1.o_done), 32'(hs && e.eof));
            if (bus1.o_done) done1_cnt++;
        end
    end

    task automatic push_frame(input logic [11:0] s);
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            e.sym = s[11-2*i -: 2];
            e.sof = (i == 0);
            e.eof = (i == 5);
            q.push_back(e);
        end
    endtask

    task automatic start_frame();
        bus.i_frame_start = 1'b1;
        @(posedge clk); #1;
        bus.i_frame_start = 1'b0;
    endtask

    task automatic send_bits(input logic [3:0] b, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                bus.i_bit_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.i_bit_valid = 1'b1;
            bus.i_bit       = b[3-i];
            @(negedge clk);
            for (int t = 0; t < 50 && !bus.o_bit_ready; t++) @(negedge clk);
            chk("bit_ready_wait", 32'(bus.o_bit_ready), 32'h1);
            @(posedge clk); #1;
        end
        bus.i_bit_valid = 1'b0;
        bus.i_bit       = 1'b0;
    endtask

    task automatic wait_idle(input int exp_done);
        @(negedge clk);
        for (int t = 0; t < 100 && bus.o_busy; t++) @(negedge clk);
        chk("busy_end", 32'(bus.o_busy), 32'h0);
        chk("queue_empty", 32'(q.size()), 32'h0);
        chk("done_count", 32'(done_cnt), 32'(exp_done));
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        rst_n = 1'b0;
        bus.i_frame_start = 1'b0; bus.i_bit_valid = 1'b0; bus.i_bit = 1'b0; bus.i_sym_ready = 1'b1;
        bus1.i_frame_start = 1'b0; bus1.i_bit_valid = 1'b0; bus1.i_bit = 1'b0; bus1.i_sym_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", 32'({bus.o_sym, bus.o_sym_valid, bus.o_sof, bus.o_eof, bus.o_done,
                               bus.o_busy, bus.o_bit_ready, bus.o_enc_en}), 32'h0);
        chk("dut1_reset_outs", 32'({bus1.o_sym, bus1.o_sym_valid, bus1.o_sof, bus1.o_eof,
                                    bus1.o_done, bus1.o_busy}), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: plain frame 1011
        push_frame(12'b11_01_00_10_10_11);
        start_frame();
        send_bits(4'b1011, 4, 1'b0);
        wait_idle(1);

        // 2: sink stalls 3 cycles after the first tail symbol is loaded
        push_frame(12'b11_01_00_10_10_11);
        start_frame();
        send_bits(4'b1011, 4, 1'b0);
        @(posedge clk); #1;
        bus.i_sym_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.i_sym_ready = 1'b1;
        wait_idle(2);

        // 3: valid gaps on the bit stream
        push_frame(12'b11_01_00_10_10_11);
        start_frame();
        send_bits(4'b1011, 4, 1'b1);
        wait_idle(3);

        // 4: back-to-back frames with start held high through the first frame
        push_frame(12'b11_01_00_10_10_11);
        push_frame(12'b00_00_00_00_00_00);
        bus.i_frame_start = 1'b1;
        send_bits(4'b1011, 4, 1'b0);
        send_bits(4'b0000, 1, 1'b0);
        bus.i_frame_start = 1'b0;
        send_bits(4'b0000, 3, 1'b0);
        wait_idle(5);

        // 5: reset after the second symbol, then a clean frame
        base = hs_cnt;
        push_frame(12'b11_01_00_10_10_11);
        start_frame();
        send_bits(4'b1011, 2, 1'b0);
        for (int t = 0; t < 50 && hs_cnt < base + 2; t++) begin
            @(posedge clk); #2;
        end
        chk("two_syms_before_reset", 32'(hs_cnt - base), 32'h2);
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        chk("midframe_reset_outs", 32'({bus.o_sym, bus.o_sym_valid, bus.o_sof, bus.o_eof,
                                        bus.o_done, bus.o_busy, bus.o_bit_ready, bus.o_enc_en}), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        push_frame(12'b11_01_00_10_10_11);
        start_frame();
        send_bits(4'b1011, 4, 1'b0);
        wait_idle(6);

        // 6: FRAME_LEN=1, TAIL_LEN=0 -> one symbol carrying both SOF and EOF
        q1.push_back('{sym: 2'b11, sof: 1'b1, eof: 1'b1});
        bus1.i_frame_start = 1'b1;
        @(posedge clk); #1;
        bus1.i_frame_start = 1'b0;
        bus1.i_bit_valid = 1'b1;
        bus1.i_bit = 1'b1;
        @(negedge clk);
        for (int t = 0; t < 50 && !bus1.o_bit_ready; t++) @(negedge clk);
        chk("dut1_bit_ready", 32'(bus1.o_bit_ready), 32'h1);
        @(posedge clk); #1;
        bus1.i_bit_valid = 1'b0;
        bus1.i_bit = 1'b0;
        @(negedge clk);
        for (int t = 0; t < 50 && bus1.o_busy; t++) @(negedge clk);
        chk("dut1_busy_end", 32'(bus1.o_busy), 32'h0);
        chk("dut1_queue_empty", 32'(q1.size()), 32'h0);
        chk("dut1_done_count", 32'(done1_cnt), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
